// File: rtl/verificador_paridade_serial.sv
// Even-parity serial receiver: reassembles a DATA_W-bit LSB-first frame plus a parity bit.
// out_valid is registered on the edge that samples the parity bit; no backpressure. Optional err_cnt: PARIDADE_ERR_COUNT_EN.
module verificador_paridade_serial #(
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              sof,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              par_err,
    output logic              busy
`ifdef PARIDADE_ERR_COUNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, DADOS, PARIDADE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_q, par_d;
    logic              err_q, err_d;
    logic              vld_q, vld_d;
`ifdef PARIDADE_ERR_COUNT_EN
    logic [7:0]        ecnt_q, ecnt_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        par_d   = par_q;
        err_d   = err_q;
        vld_d   = 1'b0;
`ifdef PARIDADE_ERR_COUNT_EN
        ecnt_d  = ecnt_q;
`endif
        if (in_valid) begin
            if (sof) begin
                // sof always restarts, silently dropping any frame in progress
                shift_d    = '0;
                shift_d[0] = in_bit;
                par_d      = in_bit;
                cnt_d      = CW'(1);
                state_d    = (DATA_W == 1) ? PARIDADE : DADOS;
            end else begin
                case (state_q)
                    DADOS: begin
                        shift_d[cnt_q] = in_bit;
                        par_d          = par_q ^ in_bit;
                        cnt_d          = cnt_q + CW'(1);
                        if (cnt_q == CW'(DATA_W - 1)) begin
                            state_d = PARIDADE;
                        end
                    end
                    PARIDADE: begin
                        data_d  = shift_q;
                        err_d   = par_q ^ in_bit;
                        vld_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
`ifdef PARIDADE_ERR_COUNT_EN
                        if ((par_q ^ in_bit) && (ecnt_q != 8'hFF)) begin
                            ecnt_d = ecnt_q + 8'd1;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
`ifdef PARIDADE_ERR_COUNT_EN
            ecnt_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            par_q   <= par_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
`ifdef PARIDADE_ERR_COUNT_EN
            ecnt_q  <= ecnt_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign out_valid = vld_q;
    assign par_err   = err_q;
    assign busy      = (state_q != IDLE);
`ifdef PARIDADE_ERR_COUNT_EN
    assign err_cnt   = ecnt_q;
`endif

endmodule

// File: tb/tb_verificador_paridade_serial.sv
// Directed bench for verificador_paridade_serial with a scoreboard of expected completed frames.
module tb_verificador_paridade_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_bit;
    logic       sof;
    logic [2:0] data_out;
    logic       out_valid;
    logic       par_err;
    logic       busy;
`ifdef PARIDADE_ERR_COUNT_EN
    logic [7:0] err_cnt;
`endif

    verificador_paridade_serial #(.DATA_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .sof       (sof),
        .data_out  (data_out),
        .out_valid (out_valid),
        .par_err   (par_err),
        .busy      (busy)
`ifdef PARIDADE_ERR_COUNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] data;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] last_data = 3'd0;
    logic       last_err  = 1'b0;
    int         model_cnt = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One input cycle; afterwards check outputs against the scoreboard and the busy expectation.
    task automatic step(input logic v, input logic b, input logic s, input logic exp_busy);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        sof      = s;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_valid_pulse", 16'(out_valid), 16'd1);
            chk("data_out", 16'(data_out), 16'(e.data));
            chk("par_err", 16'(par_err), 16'(e.err));
            last_data = e.data;
            last_err  = e.err;
            if (e.err && model_cnt < 255) model_cnt++;
        end else begin
            chk("out_valid_idle", 16'(out_valid), 16'd0);
            chk("data_out_hold", 16'(data_out), 16'(last_data));
            chk("par_err_hold", 16'(par_err), 16'(last_err));
        end
        chk("busy", 16'(busy), 16'(exp_busy));
`ifdef PARIDADE_ERR_COUNT_EN
        chk("err_cnt", 16'(err_cnt), 16'(model_cnt));
`endif
    endtask

    task automatic frame(input logic [2:0] d, input logic inject, input int gap);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, d[i], (i == 0), 1'b1);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        exp_q.push_back('{data: d, err: inject});
        step(1'b1, (^d) ^ inject, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_data_out", 16'(data_out), 16'd0);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_par_err", 16'(par_err), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
`ifdef PARIDADE_ERR_COUNT_EN
        chk("rst_err_cnt", 16'(err_cnt), 16'd0);
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        sof      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle bits without sof must be ignored
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        frame(3'b011, 1'b0, 0);
        frame(3'b001, 1'b1, 0);
        frame(3'b101, 1'b0, 2);

        // Resync: abort 3'b11x, restart with 3'b111
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        exp_q.push_back('{data: 3'b111, err: 1'b0});
        step(1'b1, 1'b1, 1'b0, 1'b0);

        // Back-to-back: new sof on the cycle out_valid is high
        frame(3'b010, 1'b1, 0);
        frame(3'b100, 1'b0, 0);

        // Reset mid-frame after two bits
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        sof      = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs();
        last_data = 3'd0;
        last_err  = 1'b0;
        model_cnt = 0;
        @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        frame(3'b110, 1'b0, 0);

        for (int v = 0; v < 8; v++) begin
            frame(3'(v), 1'b0, 0);
            frame(3'(v), 1'b1, 0);
        end

`ifdef PARIDADE_ERR_COUNT_EN
        chk("err_cnt_sweep", 16'(err_cnt), 16'd8);
        for (int k = 0; k < 300; k++) frame(3'(k), 1'b1, 0);
        chk("err_cnt_sat", 16'(err_cnt), 16'h00FF);
`endif

        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
